// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
// Optional build macro: UART_TX_2STOP_EN (two stop cycles per frame).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Output mux select encoding: A=start(0), B=stop/idle(1), C=data, D=parity
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift stage: holds the latched byte, the bit index and the
// registered serial data bit presented to the output mux.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [CNT_W-1:0]      next_cnt_s;

    assign ser_done = (bit_cnt_r == LAST_IDX);

    // Next bit index; wraps to zero after the last payload bit
    always_comb begin
        next_cnt_s = {CNT_W{1'b0}};
        if (ser_done) begin
            next_cnt_s = {CNT_W{1'b0}};
        end else begin
            next_cnt_s = bit_cnt_r + CNT_W'(1);
        end
    end

    // Load on accept so bit 0 is already on ser_data during START; advance in DATA
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            ser_data  <= 1'b0;
        end else if (load) begin
            data_r    <= p_data;
            bit_cnt_r <= {CNT_W{1'b0}};
            ser_data  <= p_data[0];
        end else if (shift_en) begin
            bit_cnt_r <= next_cnt_s;
            ser_data  <= data_r[next_cnt_s];
        end else begin
            bit_cnt_r <= bit_cnt_r;
            ser_data  <= ser_data;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer driving the TX 4:1 output mux.
// Frame: start, LSB-first data, optional parity, stop; one CLK per bit.
// Optional build macro: UART_TX_2STOP_EN stretches STOP to two cycles.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    state_t state;
    logic   par_en_r;
    logic   stop_last_s;
    logic   load_s;
    logic   shift_en_s;
    logic   ser_done_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        if (typ == PAR_EVEN) begin
            return ^d;
        end else begin
            return ~^d;
        end
    endfunction

`ifdef UART_TX_2STOP_EN
    logic stop_cnt_r;

    // Tracks which of the two stop cycles is current
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop_cnt_r <= 1'b0;
        end else if (state == STOP) begin
            stop_cnt_r <= ~stop_cnt_r;
        end else begin
            stop_cnt_r <= 1'b0;
        end
    end

    assign stop_last_s = stop_cnt_r;
`else
    assign stop_last_s = 1'b1;
`endif

    // A new byte is taken only when idle or at the very end of the stop period
    assign load_s     = Data_Valid && ((state == IDLE) || ((state == STOP) && stop_last_s));
    assign shift_en_s = (state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load_s),
        .shift_en (shift_en_s),
        .p_data   (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done_s)
    );

    // Frame sequencer with registered mux select, parity and busy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            mux_sel  <= SEL_STOP;
            par_bit  <= 1'b0;
            busy     <= 1'b0;
            par_en_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_s) begin
                        state    <= START;
                        mux_sel  <= SEL_START;
                        busy     <= 1'b1;
                        par_en_r <= PAR_EN;
                        par_bit  <= calc_parity(P_DATA, PAR_TYP);
                    end else begin
                        mux_sel  <= SEL_STOP;
                        busy     <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    mux_sel <= SEL_DATA;
                end
                DATA: begin
                    if (ser_done_s && par_en_r) begin
                        state   <= PARITY;
                        mux_sel <= SEL_PAR;
                    end else if (ser_done_s) begin
                        state   <= STOP;
                        mux_sel <= SEL_STOP;
                    end else begin
                        mux_sel <= SEL_DATA;
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    mux_sel <= SEL_STOP;
                end
                STOP: begin
                    if (!stop_last_s) begin
                        mux_sel <= SEL_STOP;
                    end else if (load_s) begin
                        // Back-to-back frame: straight into START, busy stays high
                        state    <= START;
                        mux_sel  <= SEL_START;
                        busy     <= 1'b1;
                        par_en_r <= PAR_EN;
                        par_bit  <= calc_parity(P_DATA, PAR_TYP);
                    end else begin
                        state   <= IDLE;
                        mux_sel <= SEL_STOP;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
